// File: rtl/pipeline_stage_chain_if.sv
// Handshake and observation bundle for pipeline_stage_chain. The master drives
// fetch data and the hazard/branch requests; the slave is the stage chain.
interface pipeline_stage_chain_if #(
  parameter int STAGES = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic [STAGES-1:0]        stall_req;
  logic [STAGES-1:0]        flush_req;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES*DATA_W-1:0] stage_data;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CNT_W-1:0]         retire_count;
  logic [CNT_W-1:0]         bubble_count;

  modport master (
    output in_valid, in_data, stall_req, flush_req,
    input  in_ready, stage_valid, stage_data, out_valid, out_data,
           retire_count, bubble_count
  );

  modport slave (
    input  in_valid, in_data, stall_req, flush_req,
    output in_ready, stage_valid, stage_data, out_valid, out_data,
           retire_count, bubble_count
  );
endinterface

// File: rtl/pipeline_stage_chain.sv
// Chain of STAGES boundary registers with per-stage stall/flush, automatic
// NOP bubble insertion, an input ready handshake and saturating counters.
module pipeline_stage_chain #(
  parameter int STAGES = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_stage_chain_if.slave  bus
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [CNT_W-1:0]  retire_q;
  logic [CNT_W-1:0]  bubble_q;
  logic              retire_fire;
  logic              bubble_fire;

  // A stall or flush on stage k reaches every younger stage below it.
  always_comb begin
    hold = '0;
    kill = '0;
    hold[STAGES-1] = bus.stall_req[STAGES-1];
    kill[STAGES-1] = bus.flush_req[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      hold[k] = hold[k+1] | bus.stall_req[k];
      kill[k] = kill[k+1] | bus.flush_req[k];
    end
  end

  // NOTE: every signal gets a default first so no path through the
  // priority chain leaves one unassigned and infers a latch.
  always_comb begin
    valid_d     = '0;
    bubble_fire = 1'b0;
    for (int k = 0; k < STAGES; k++) data_d[k] = '0;

    if (!kill[0]) begin
      if (hold[0]) begin
        valid_d[0] = valid_q[0];
        data_d[0]  = data_q[0];
      end else begin
        valid_d[0] = bus.in_valid;
        data_d[0]  = bus.in_valid ? bus.in_data : '0;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (kill[k]) begin
        valid_d[k] = 1'b0;
      end else if (hold[k]) begin
        valid_d[k] = valid_q[k];
        data_d[k]  = data_q[k];
      end else if (hold[k-1] && !kill[k-1]) begin
        // Older neighbour is really frozen: insert a NOP. A killed neighbour
        // is not frozen, so this stage advances its old contents instead.
        bubble_fire = 1'b1;
      end else begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  assign retire_fire = valid_q[STAGES-1] & ~bus.stall_req[STAGES-1] & ~kill[STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  // NOTE: the stage payload registers are reset as well, because an invalid
  // stage must read as all-zero (NOP) downstream, including right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      retire_q <= '0;
      bubble_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
      if (retire_fire && (retire_q != '1)) retire_q <= retire_q + CNT_W'(1);
      if (bubble_fire && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign bus.in_ready     = ~hold[0] & ~|bus.flush_req;
  assign bus.stage_valid  = valid_q;
  assign bus.out_valid    = valid_q[STAGES-1];
  assign bus.out_data     = data_q[STAGES-1];
  assign bus.retire_count = retire_q;
  assign bus.bubble_count = bubble_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign bus.stage_data[g*DATA_W +: DATA_W] = data_q[g];
  end

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Directed bench for pipeline_stage_chain (STAGES=4, DATA_W=8, CNT_W=4) with a
// per-cycle comparison against a stage-index-based behavioural model.
module tb_pipeline_stage_chain;
  localparam int S  = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  pipeline_stage_chain_if #(.STAGES(S), .DATA_W(DW), .CNT_W(CW)) bus ();

  pipeline_stage_chain #(.STAGES(S), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: what each stage register must hold after each edge.
  bit       m_valid [S];
  bit [7:0] m_data  [S];
  int       m_ret = 0;
  int       m_bub = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model works from the highest flushed index f and highest stalled
  // index s: stages 0..f die, stages f+1..s freeze, stage s+1 receives a NOP
  // when stage s is genuinely frozen, everything else shifts by one.
  always @(posedge clk) begin
    int       f, s;
    bit       nv [S];
    bit [7:0] nd [S];
    f = -1;
    s = -1;
    for (int k = 0; k < S; k++) begin
      if (bus.flush_req[k]) f = k;
      if (bus.stall_req[k]) s = k;
    end
    if (reset) begin
      for (int k = 0; k < S; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = 8'h00;
      end
      m_ret = 0;
      m_bub = 0;
    end else begin
      if (m_valid[S-1] && !bus.stall_req[S-1] && f != S-1 && m_ret < CNT_MAX) m_ret++;
      if (s >= 0 && s < S-1 && s > f && m_bub < CNT_MAX) m_bub++;
      for (int k = 0; k < S; k++) begin
        if (k <= f) begin
          nv[k] = 1'b0; nd[k] = 8'h00;
        end else if (k <= s) begin
          nv[k] = m_valid[k]; nd[k] = m_data[k];
        end else if (k == 0) begin
          nv[k] = bus.in_valid; nd[k] = bus.in_valid ? bus.in_data : 8'h00;
        end else if (k - 1 == s && s > f) begin
          nv[k] = 1'b0; nd[k] = 8'h00;
        end else begin
          nv[k] = m_valid[k-1]; nd[k] = m_data[k-1];
        end
      end
      for (int k = 0; k < S; k++) begin
        m_valid[k] = nv[k];
        m_data[k]  = nd[k];
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [S-1:0]    ev;
      logic [S*DW-1:0] ed;
      for (int k = 0; k < S; k++) begin
        ev[k]           = m_valid[k];
        ed[k*DW +: DW]  = m_data[k];
      end
      check("stage_valid", 64'(bus.stage_valid), 64'(ev));
      check("stage_data", 64'(bus.stage_data), 64'(ed));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid[S-1]));
      check("out_data", 64'(bus.out_data), 64'(m_data[S-1]));
      check("retire_count", 64'(bus.retire_count), 64'(m_ret));
      check("bubble_count", 64'(bus.bubble_count), 64'(m_bub));
      check("in_ready", 64'(bus.in_ready), 64'(~|bus.stall_req & ~|bus.flush_req));
    end
  end

  task automatic set_in(input bit r, input bit v, input logic [7:0] d,
                        input logic [3:0] st, input logic [3:0] fl);
    reset         = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.stall_req = st;
    bus.flush_req = fl;
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] d,
                     input logic [3:0] st, input logic [3:0] fl);
    set_in(r, v, d, st, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset with in_valid high
    cyc(1, 1, 8'h5A, 4'b0000, 4'b0000);
    chk_en = 1'b1;
    cyc(1, 1, 8'h5A, 4'b0000, 4'b0000);
    check("rst_valid", 64'(bus.stage_valid), 64'h0);
    check("rst_data", 64'(bus.stage_data), 64'h0);
    check("rst_retire", 64'(bus.retire_count), 64'h0);
    check("rst_bubble", 64'(bus.bubble_count), 64'h0);
    set_in(0, 0, 8'h00, 4'b0000, 4'b0000);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);

    // 2: stream five payloads
    cyc(0, 1, 8'h11, 4'b0000, 4'b0000);
    cyc(0, 1, 8'h22, 4'b0000, 4'b0000);
    cyc(0, 1, 8'h33, 4'b0000, 4'b0000);
    cyc(0, 1, 8'h44, 4'b0000, 4'b0000);
    check("lat_out_data", 64'(bus.out_data), 64'h11);
    cyc(0, 1, 8'h55, 4'b0000, 4'b0000);
    check("stream_out_22", 64'(bus.out_data), 64'h22);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 4'b0000, 4'b0000);
    check("stream_retire", 64'(bus.retire_count), 64'd5);

    // 3: load-use stall on stage 1
    cyc(0, 1, 8'hA1, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hA2, 4'b0000, 4'b0000);
    set_in(0, 1, 8'hA3, 4'b0010, 4'b0000);
    #1;
    check("lu_in_ready", 64'(bus.in_ready), 64'h0);
    cyc(0, 1, 8'hA3, 4'b0010, 4'b0000);
    check("lu_data", 64'(bus.stage_data), 64'h0000A1A2);
    check("lu_valid", 64'(bus.stage_valid), 64'b0011);
    check("lu_bubble", 64'(bus.bubble_count), 64'd1);
    cyc(0, 1, 8'hA3, 4'b0000, 4'b0000);

    // 4: branch flush and stall on stage 2 together
    set_in(0, 1, 8'hB0, 4'b0100, 4'b0100);
    #1;
    check("br_in_ready", 64'(bus.in_ready), 64'h0);
    cyc(0, 1, 8'hB0, 4'b0100, 4'b0100);
    check("br_data", 64'(bus.stage_data), 64'hA1000000);
    check("br_valid", 64'(bus.stage_valid), 64'b1000);
    check("br_bubble", 64'(bus.bubble_count), 64'd1);
    cyc(0, 0, 8'h00, 4'b0000, 4'b0000);
    check("br_retire", 64'(bus.retire_count), 64'd6);

    // stall on the last stage: output frozen, nothing retires
    cyc(0, 1, 8'hC4, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hC3, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hC2, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hC1, 4'b0000, 4'b0000);
    cyc(0, 0, 8'h00, 4'b1000, 4'b0000);
    cyc(0, 0, 8'h00, 4'b1000, 4'b0000);
    check("last_stall_data", 64'(bus.stage_data), 64'hC4C3C2C1);
    check("last_stall_out", 64'(bus.out_data), 64'hC4);
    check("last_stall_retire", 64'(bus.retire_count), 64'd6);

    // flush stage 1 with stall stage 2: 0..1 killed, 2 held, 3 bubble
    cyc(0, 0, 8'h00, 4'b0100, 4'b0010);
    check("mix_data", 64'(bus.stage_data), 64'h00C30000);
    check("mix_valid", 64'(bus.stage_valid), 64'b0100);
    check("mix_bubble", 64'(bus.bubble_count), 64'd2);
    check("mix_retire", 64'(bus.retire_count), 64'd7);
    cyc(0, 0, 8'h00, 4'b0000, 4'b0000);
    cyc(0, 0, 8'h00, 4'b0000, 4'b0000);
    check("mix_drain_retire", 64'(bus.retire_count), 64'd8);

    // 5: retire counter saturation
    for (int i = 0; i < 20; i++) cyc(0, 1, 8'(8'h60 + i), 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 4'b0000, 4'b0000);
    check("sat_retire", 64'(bus.retire_count), 64'hF);
    check("sat_bubble", 64'(bus.bubble_count), 64'd2);

    // 6: reset in the middle of a full stall
    cyc(0, 1, 8'hE1, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hE2, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hE3, 4'b1111, 4'b0000);
    cyc(0, 1, 8'hE3, 4'b1111, 4'b0000);
    cyc(1, 1, 8'hE3, 4'b1111, 4'b0000);
    check("mid_rst_valid", 64'(bus.stage_valid), 64'h0);
    check("mid_rst_data", 64'(bus.stage_data), 64'h0);
    check("mid_rst_retire", 64'(bus.retire_count), 64'h0);
    check("mid_rst_bubble", 64'(bus.bubble_count), 64'h0);
    cyc(0, 1, 8'hE3, 4'b1111, 4'b0000);
    cyc(0, 1, 8'hD1, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hD2, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hD3, 4'b0000, 4'b0000);
    cyc(0, 1, 8'hD4, 4'b0000, 4'b0000);
    check("refill_out", 64'(bus.out_data), 64'hD1);
    check("refill_data", 64'(bus.stage_data), 64'hD1D2D3D4);
    cyc(0, 0, 8'h00, 4'b0000, 4'b0000);
    check("refill_retire", 64'(bus.retire_count), 64'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
